// File: rtl/counter_ctrl.sv
// ---------------------------------------------------------------------------
// counter_ctrl
//   Run/stop/clear controlled event counter for a 4-digit FND display path.
//   Three asynchronous button levels are synchronized, edge-detected and fed
//   to an IDLE/RUN/PAUSE state machine. A prescaler divides i_clk by TICK_DIV
//   while running; each prescaler terminal count is a tick that steps the
//   counter through 0..MAX_COUNT with wrap-around.
//
//   Optional feature macro: COUNTER_CTRL_DOWN_EN
//     When defined, adds input i_down; a tick taken while i_down is high
//     decrements the counter (0 wraps to MAX_COUNT). When undefined the
//     port is absent and counting is up-only.
//
// Parameters
//   TICK_DIV   i_clk cycles per count step (>= 2)
//   MAX_COUNT  terminal count value (must fit in 14 bits)
//
// Ports
//   i_clk      system clock, rising edge
//   i_reset    asynchronous active-high reset
//   i_run      asynchronous level, rising edge = run command
//   i_stop     asynchronous level, rising edge = stop command
//   i_clear    asynchronous level, rising edge = clear command
//   i_down     (COUNTER_CTRL_DOWN_EN only) count direction, 1 = down
//   o_counter  current count value, 0..MAX_COUNT
//   o_running  high while the state is RUN
//   o_tick     one-cycle pulse on the cycle a count step is due
//   o_wrap     one-cycle pulse coincident with the wrapped counter value
// ---------------------------------------------------------------------------
module counter_ctrl #(
  parameter int TICK_DIV  = 100000000,
  parameter int MAX_COUNT = 9999
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_run,
  input  logic        i_stop,
  input  logic        i_clear,
`ifdef COUNTER_CTRL_DOWN_EN
  input  logic        i_down,
`endif
  output logic [13:0] o_counter,
  output logic        o_running,
  output logic        o_tick,
  output logic        o_wrap
);

  localparam int          PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_ZERO = PW'(0);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
  localparam logic [13:0] COUNT_MAX  = 14'(MAX_COUNT);

  // Command bit positions inside the synchronizer vectors.
  localparam int CMD_RUN   = 0;
  localparam int CMD_STOP  = 1;
  localparam int CMD_CLEAR = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // Input conditioning
  // -------------------------------------------------------------------------
  logic [2:0] sync1_r;
  logic [2:0] sync2_r;
  logic [2:0] edge_r;
  logic [1:0] arm_cnt_r;
  logic       armed_s;
  logic [2:0] cmd_s;
  logic       run_cmd_s;
  logic       stop_cmd_s;
  logic       clear_cmd_s;
  logic       down_s;

  // Two-flop synchronizer for the three command buttons.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync1_r <= 3'b000;
      sync2_r <= 3'b000;
    end else begin
      sync1_r <= {i_clear, i_stop, i_run};
      sync2_r <= sync1_r;
    end
  end

  // Edge-detect history: previous synchronized level of each button.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      edge_r <= 3'b000;
    end else begin
      edge_r <= sync2_r;
    end
  end

  // Post-reset arming counter. The synchronizer restarts from zero, so a
  // button held through reset release would look like a fresh rising edge
  // while it propagates. Commands stay masked until the edge history has
  // loaded the settled synchronizer output.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      arm_cnt_r <= 2'd0;
    end else if (arm_cnt_r != 2'd3) begin
      arm_cnt_r <= arm_cnt_r + 2'd1;
    end else begin
      arm_cnt_r <= 2'd3;
    end
  end

  assign armed_s     = (arm_cnt_r == 2'd3);
  assign cmd_s       = sync2_r & ~edge_r & {3{armed_s}};
  assign run_cmd_s   = cmd_s[CMD_RUN];
  assign stop_cmd_s  = cmd_s[CMD_STOP];
  assign clear_cmd_s = cmd_s[CMD_CLEAR];

`ifdef COUNTER_CTRL_DOWN_EN
  logic down_sync1_r;
  logic down_sync2_r;

  // Two-flop synchronizer for the direction level (sampled per tick, no edge).
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      down_sync1_r <= 1'b0;
      down_sync2_r <= 1'b0;
    end else begin
      down_sync1_r <= i_down;
      down_sync2_r <= down_sync1_r;
    end
  end

  assign down_s = down_sync2_r;
`else
  assign down_s = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // State machine
  // -------------------------------------------------------------------------
  state_t        state_r;
  state_t        next_state_s;
  logic [PW-1:0] presc_r;
  logic [13:0]   counter_r;
  logic          running_r;
  logic          tick_r;
  logic          wrap_r;

  logic [PW-1:0] presc_next_s;
  logic [13:0]   counter_next_s;
  logic          step_s;
  logic          wrap_next_s;
  logic          tick_next_s;
  logic          running_next_s;

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode; only the highest-priority command (clear > stop > run)
  // is considered, lower-priority commands in the same cycle are dropped.
  always_comb begin
    next_state_s = state_r;
    if (clear_cmd_s) begin
      next_state_s = ST_IDLE;
    end else if (stop_cmd_s) begin
      case (state_r)
        ST_RUN:  next_state_s = ST_PAUSE;
        default: next_state_s = state_r;
      endcase
    end else if (run_cmd_s) begin
      case (state_r)
        ST_IDLE:  next_state_s = ST_RUN;
        ST_PAUSE: next_state_s = ST_RUN;
        default:  next_state_s = state_r;
      endcase
    end else begin
      next_state_s = state_r;
    end
  end

  // Datapath decode: prescaler, count step, and next values of the outputs.
  always_comb begin
    presc_next_s   = presc_r;
    counter_next_s = counter_r;
    wrap_next_s    = 1'b0;

    // A stop or clear landing on the tick cycle cancels the step.
    step_s = (state_r == ST_RUN) && (presc_r == PRESC_LAST) &&
             !stop_cmd_s && !clear_cmd_s;

    // Prescaler: zero in IDLE, free-run in RUN, hold otherwise (PAUSE, and
    // the stop edge itself so a resume finishes the partial prescale).
    if (next_state_s == ST_IDLE) begin
      presc_next_s = PRESC_ZERO;
    end else if ((state_r == ST_RUN) && (next_state_s == ST_RUN)) begin
      if (presc_r >= PRESC_LAST) begin
        presc_next_s = PRESC_ZERO;
      end else begin
        presc_next_s = presc_r + PRESC_ONE;
      end
    end else begin
      presc_next_s = presc_r;
    end

    // Counter: range-checked with >= / == so it can never leave 0..MAX.
    if (next_state_s == ST_IDLE) begin
      counter_next_s = 14'd0;
    end else if (step_s) begin
      if (down_s) begin
        if ((counter_r == 14'd0) || (counter_r > COUNT_MAX)) begin
          counter_next_s = COUNT_MAX;
          wrap_next_s    = 1'b1;
        end else begin
          counter_next_s = counter_r - 14'd1;
        end
      end else begin
        if (counter_r >= COUNT_MAX) begin
          counter_next_s = 14'd0;
          wrap_next_s    = 1'b1;
        end else begin
          counter_next_s = counter_r + 14'd1;
        end
      end
    end else begin
      counter_next_s = counter_r;
    end

    // Outputs are registered from next-state values so they line up with
    // the state and prescaler they describe.
    running_next_s = (next_state_s == ST_RUN);
    tick_next_s    = (next_state_s == ST_RUN) && (presc_next_s == PRESC_LAST);
  end

  // Prescaler and counter registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      presc_r   <= PRESC_ZERO;
      counter_r <= 14'd0;
    end else begin
      presc_r   <= presc_next_s;
      counter_r <= counter_next_s;
    end
  end

  // Registered status outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      running_r <= 1'b0;
      tick_r    <= 1'b0;
      wrap_r    <= 1'b0;
    end else begin
      running_r <= running_next_s;
      tick_r    <= tick_next_s;
      wrap_r    <= wrap_next_s;
    end
  end

  assign o_counter = counter_r;
  assign o_running = running_r;
  assign o_tick    = tick_r;
  assign o_wrap    = wrap_r;

endmodule

// File: tb/tb_counter_ctrl.sv
module tb_counter_ctrl;

  logic        i_clk;
  logic        i_reset;
  logic        i_run;
  logic        i_stop;
  logic        i_clear;
  logic        i_down;
  logic [13:0] o_counter;
  logic        o_running;
  logic        o_tick;
  logic        o_wrap;

  int n_cmp;
  int n_fail;

  counter_ctrl #(
    .TICK_DIV (4),
    .MAX_COUNT(9999)
  ) dut (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_run    (i_run),
    .i_stop   (i_stop),
    .i_clear  (i_clear),
`ifdef COUNTER_CTRL_DOWN_EN
    .i_down   (i_down),
`endif
    .o_counter(o_counter),
    .o_running(o_running),
    .o_tick   (o_tick),
    .o_wrap   (o_wrap)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  // Wait (bounded) for o_tick; returns cycles waited.
  task automatic wait_tick(output int waited);
    waited = 0;
    do begin
      cyc(1);
      waited++;
    end while (o_tick !== 1'b1 && waited < 20);
  endtask

  task automatic test_reset;
    i_reset = 1'b1;
    cyc(2);
    n_cmp++; if (o_counter !== 14'd0) begin n_fail++; $display("FAIL reset_counter got=%0d exp=0", o_counter); end
    n_cmp++; if (o_running !== 1'b0) begin n_fail++; $display("FAIL reset_running got=%b exp=0", o_running); end
    n_cmp++; if (o_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick got=%b exp=0", o_tick); end
    n_cmp++; if (o_wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap got=%b exp=0", o_wrap); end
    i_reset = 1'b0;
    cyc(4);
  endtask

  task automatic test_run;
    int w;
    i_run = 1'b1;
    cyc(2);
    n_cmp++; if (o_running !== 1'b0) begin n_fail++; $display("FAIL run_early got=%b exp=0", o_running); end
    cyc(1);
    n_cmp++; if (o_running !== 1'b1) begin n_fail++; $display("FAIL run_edge3 got=%b exp=1", o_running); end
    i_run = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      wait_tick(w);
      n_cmp++; if (w !== 3) begin n_fail++; $display("FAIL tick_spacing_%0d got=%0d exp=3", k, w); end
      cyc(1);
      n_cmp++; if (o_counter !== 14'(k)) begin n_fail++; $display("FAIL count_%0d got=%0d exp=%0d", k, o_counter, k); end
    end
  endtask

  task automatic test_pause_resume;
    int w;
    // Prescaler is 0 now; stop lands when it has reached 2.
    i_stop = 1'b1;
    cyc(3);
    n_cmp++; if (o_running !== 1'b0) begin n_fail++; $display("FAIL pause_running got=%b exp=0", o_running); end
    i_stop = 1'b0;
    for (int i = 0; i < 50; i++) begin
      cyc(1);
      n_cmp++;
      if (o_tick !== 1'b0 || o_counter !== 14'd5) begin
        n_fail++; $display("FAIL pause_hold cyc=%0d tick=%b cnt=%0d exp tick=0 cnt=5", i, o_tick, o_counter);
      end
    end
    i_run = 1'b1;
    cyc(3);
    n_cmp++; if (o_running !== 1'b1) begin n_fail++; $display("FAIL resume_running got=%b exp=1", o_running); end
    i_run = 1'b0;
    wait_tick(w);
    n_cmp++; if (w !== 1) begin n_fail++; $display("FAIL resume_remaining got=%0d exp=1", w); end
    cyc(1);
    n_cmp++; if (o_counter !== 14'd6) begin n_fail++; $display("FAIL resume_count got=%0d exp=6", o_counter); end
  endtask

  task automatic test_wrap;
    int w;
    int guard;
    logic over;
    over  = 1'b0;
    guard = 0;
    while (o_counter !== 14'd9998 && guard < 50000) begin
      cyc(1);
      guard++;
      if (o_counter > 14'd9999) over = 1'b1;
    end
    n_cmp++; if (o_counter !== 14'd9998) begin n_fail++; $display("FAIL reach_9998 got=%0d exp=9998", o_counter); end
    n_cmp++; if (over !== 1'b0) begin n_fail++; $display("FAIL range got=%b exp=0", over); end
    wait_tick(w);
    cyc(1);
    n_cmp++; if (o_counter !== 14'd9999) begin n_fail++; $display("FAIL wrap_9999 got=%0d exp=9999", o_counter); end
    n_cmp++; if (o_wrap !== 1'b0) begin n_fail++; $display("FAIL wrap_early got=%b exp=0", o_wrap); end
    wait_tick(w);
    n_cmp++; if (w !== 3) begin n_fail++; $display("FAIL wrap_spacing got=%0d exp=3", w); end
    cyc(1);
    n_cmp++; if (o_counter !== 14'd0) begin n_fail++; $display("FAIL wrap_zero got=%0d exp=0", o_counter); end
    n_cmp++; if (o_wrap !== 1'b1) begin n_fail++; $display("FAIL wrap_pulse got=%b exp=1", o_wrap); end
    cyc(1);
    n_cmp++; if (o_wrap !== 1'b0) begin n_fail++; $display("FAIL wrap_single got=%b exp=0", o_wrap); end
  endtask

  task automatic test_priority;
    int w;
    wait_tick(w); cyc(1);
    wait_tick(w); cyc(1);
    n_cmp++; if (o_counter !== 14'd2) begin n_fail++; $display("FAIL prio_pre got=%0d exp=2", o_counter); end
    i_stop = 1'b1;
    cyc(3);
    i_stop = 1'b0;
    cyc(4);
    n_cmp++; if (o_counter !== 14'd2) begin n_fail++; $display("FAIL prio_paused got=%0d exp=2", o_counter); end
    // run + clear on the same edge in PAUSE: clear wins.
    i_run = 1'b1; i_clear = 1'b1;
    cyc(3);
    n_cmp++; if (o_running !== 1'b0) begin n_fail++; $display("FAIL clear_running got=%b exp=0", o_running); end
    n_cmp++; if (o_counter !== 14'd0) begin n_fail++; $display("FAIL clear_count got=%0d exp=0", o_counter); end
    i_run = 1'b0; i_clear = 1'b0;
    cyc(4);
    n_cmp++; if (o_running !== 1'b0) begin n_fail++; $display("FAIL clear_stays_idle got=%b exp=0", o_running); end
    // Restart: prescaler must have been zeroed by the clear.
    i_run = 1'b1;
    cyc(3);
    i_run = 1'b0;
    wait_tick(w);
    n_cmp++; if (w !== 3) begin n_fail++; $display("FAIL clear_presc got=%0d exp=3", w); end
    cyc(1);
    n_cmp++; if (o_counter !== 14'd1) begin n_fail++; $display("FAIL restart_count got=%0d exp=1", o_counter); end
    // stop + run on the same edge in RUN: stop wins.
    i_stop = 1'b1; i_run = 1'b1;
    cyc(3);
    n_cmp++; if (o_running !== 1'b0) begin n_fail++; $display("FAIL stop_over_run got=%b exp=0", o_running); end
    i_stop = 1'b0; i_run = 1'b0;
    cyc(4);
  endtask

  task automatic test_reset_held_run;
    int w;
    i_run = 1'b1;
    cyc(5);
    n_cmp++; if (o_running !== 1'b1) begin n_fail++; $display("FAIL pre_reset_run got=%b exp=1", o_running); end
    i_reset = 1'b1;
    cyc(2);
    n_cmp++; if (o_counter !== 14'd0) begin n_fail++; $display("FAIL midrun_reset_count got=%0d exp=0", o_counter); end
    n_cmp++; if (o_running !== 1'b0) begin n_fail++; $display("FAIL midrun_reset_running got=%b exp=0", o_running); end
    i_reset = 1'b0;
    cyc(8);
    n_cmp++; if (o_running !== 1'b0) begin n_fail++; $display("FAIL held_button got=%b exp=0", o_running); end
    i_run = 1'b0;
    cyc(4);
    i_run = 1'b1;
    cyc(3);
    n_cmp++; if (o_running !== 1'b1) begin n_fail++; $display("FAIL rerun got=%b exp=1", o_running); end
    i_run = 1'b0;
    wait_tick(w);
    n_cmp++; if (w !== 3) begin n_fail++; $display("FAIL rerun_presc got=%0d exp=3", w); end
    cyc(1);
    n_cmp++; if (o_counter !== 14'd1) begin n_fail++; $display("FAIL rerun_count got=%0d exp=1", o_counter); end
  endtask

`ifdef COUNTER_CTRL_DOWN_EN
  task automatic test_down;
    int w;
    i_clear = 1'b1;
    cyc(3);
    i_clear = 1'b0;
    i_down  = 1'b1;
    cyc(4);
    i_run = 1'b1;
    cyc(3);
    i_run = 1'b0;
    wait_tick(w); cyc(1);
    n_cmp++; if (o_counter !== 14'd9999) begin n_fail++; $display("FAIL down_wrap got=%0d exp=9999", o_counter); end
    n_cmp++; if (o_wrap !== 1'b1) begin n_fail++; $display("FAIL down_wrap_pulse got=%b exp=1", o_wrap); end
    wait_tick(w); cyc(1);
    n_cmp++; if (o_counter !== 14'd9998) begin n_fail++; $display("FAIL down_9998 got=%0d exp=9998", o_counter); end
    wait_tick(w); cyc(1);
    n_cmp++; if (o_counter !== 14'd9997) begin n_fail++; $display("FAIL down_9997 got=%0d exp=9997", o_counter); end
    i_down = 1'b0;
  endtask
`endif

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    i_reset = 1'b1;
    i_run   = 1'b0;
    i_stop  = 1'b0;
    i_clear = 1'b0;
    i_down  = 1'b0;
    test_reset();
    test_run();
    test_pause_resume();
    test_wrap();
    test_priority();
    test_reset_held_run();
`ifdef COUNTER_CTRL_DOWN_EN
    test_down();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
